// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage of the miniRV core.
// Holds the PC and fetches one instruction at a time over a req/gnt/rvalid
// handshake. It presents that instruction to the decoder until the core acks it,
// and then moves to the next PC chosen by npc_op.
// A misaligned next PC or a memory timeout puts the unit in a halt state.
// The halt state is sticky and only reset leaves it.
//
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   imem_req/imem_addr  fetch request (S_REQ only) and its address (= pc)
//   imem_gnt            memory accepted the request this cycle
//   imem_rvalid/rdata   fetched word strobe and data
//   inst/inst_valid     instruction to the decoder, held until inst_ack
//   pc/pc4              address of inst and that address + 4
//   inst_ack            core finished inst; npc_op/br_*/jmp_target valid now
//   npc_op              00 pc+4, 01 conditional branch, 10 absolute jump, 11 pc+4
//   br_taken/br_offset  branch condition and sign-extended B-type immediate
//   jmp_target          absolute jump target from EX
//   fault/fault_cause   sticky fault flag; cause 01 misaligned, 10 timeout
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  input  logic        inst_ack,
  input  logic [1:0]  npc_op,
  input  logic        br_taken,
  input  logic [31:0] br_offset,
  input  logic [31:0] jmp_target,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] NPC_JMP    = 2'b01;
  localparam logic [1:0] NPC_ABSJMP = 2'b10;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      npc;

  // The fetch address is the architectural PC itself, so it is stable for the whole request.
  assign imem_addr = pc;

  // Next-PC selection. It is only consumed in the ack cycle of S_HOLD.
  always_comb begin
    npc = pc + 32'd4;
    case (npc_op)
      NPC_JMP:    if (br_taken) npc = pc + br_offset;
      NPC_ABSJMP: npc = {jmp_target[31:1], 1'b0};
      default:    ;
    endcase
  end

  // Fetch FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      pc4         <= RESET_PC + 32'd4;
      inst        <= 32'd0;
      inst_valid  <= 1'b0;
      imem_req    <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= 2'b00;
      wait_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_REQ;
          imem_req <= 1'b1;
          wait_cnt <= '0;
        end

        S_REQ: begin
          if (imem_gnt && imem_rvalid) begin
            inst       <= imem_rdata;
            inst_valid <= 1'b1;
            imem_req   <= 1'b0;
            state      <= S_HOLD;
          end else if (wait_cnt == CNT_LAST) begin
            fault       <= 1'b1;
            fault_cause <= CAUSE_TIMEOUT;
            imem_req    <= 1'b0;
            state       <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
            if (imem_gnt) begin
              imem_req <= 1'b0;
              state    <= S_WAIT;
            end
          end
        end

        // An rvalid in the final counted cycle takes priority over the timeout.
        S_WAIT: begin
          if (imem_rvalid) begin
            inst       <= imem_rdata;
            inst_valid <= 1'b1;
            state      <= S_HOLD;
          end else if (wait_cnt == CNT_LAST) begin
            fault       <= 1'b1;
            fault_cause <= CAUSE_TIMEOUT;
            state       <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        // A misaligned target is still loaded into pc so a debugger can see where the jump went.
        S_HOLD: begin
          if (inst_ack) begin
            pc         <= npc;
            pc4        <= npc + 32'd4;
            inst_valid <= 1'b0;
            if (npc[1]) begin
              fault       <= 1'b1;
              fault_cause <= CAUSE_MISALIGN;
              state       <= S_HALT;
            end else begin
              imem_req <= 1'b1;
              wait_cnt <= '0;
              state    <= S_REQ;
            end
          end
        end

        S_HALT: begin
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
        end

        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Testbench for ifetch_unit.
// It drives directed and randomized fetch/ack sequences.
// The expected PC stream comes from a next-PC reference function.
// Instruction words come from an address-hashed memory image.
module tb_ifetch_unit;

  localparam int unsigned TO = 8;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        inst_ack = 1'b0;
  logic [1:0]  npc_op = 2'b00;
  logic        br_taken = 1'b0;
  logic [31:0] br_offset = 32'd0;
  logic [31:0] jmp_target = 32'd0;
  logic        fault;
  logic [1:0]  fault_cause;

  int checks = 0;
  int errors = 0;

  ifetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst(inst), .inst_valid(inst_valid), .pc(pc), .pc4(pc4),
    .inst_ack(inst_ack), .npc_op(npc_op), .br_taken(br_taken),
    .br_offset(br_offset), .jmp_target(jmp_target),
    .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Memory image: instruction word is a hash of its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Reference next-PC rule.
  function automatic logic [31:0] ref_npc(input logic [31:0] cur, input logic [1:0] op,
                                          input logic bt, input logic [31:0] off,
                                          input logic [31:0] tgt);
    if (op == 2'b10) return tgt & 32'hFFFF_FFFE;
    if (op == 2'b01 && bt) return cur + off;
    return cur + 32'd4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reset pulse. After release, the unit is in its first request cycle.
  task automatic do_reset();
    rst = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ack = 1'b0;
    tick(); tick();
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_ival",  32'(inst_valid), 32'd0);
    chk("rst_pc",    pc, RST_PC);
    chk("rst_inst",  inst, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_cause", 32'(fault_cause), 32'd0);
    rst = 1'b0;
    tick();
  endtask

  // One fetch: g cycles without gnt, then gnt. rvalid comes w cycles later (0 = same cycle).
  // A stray ack is asserted outside S_HOLD. It carries a misaligned jump, and the unit must ignore it.
  task automatic do_fetch(input logic [31:0] exp_pc, input int g, input int w);
    chk("fetch_req",  32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr, exp_pc);
    chk("fetch_ival", 32'(inst_valid), 32'd0);
    inst_ack = (g > 0); npc_op = 2'b10; jmp_target = 32'h0000_0002;
    repeat (g) tick();
    inst_ack = 1'b0;
    chk("addr_stable", imem_addr, exp_pc);
    imem_gnt = 1'b1;
    imem_rvalid = (w == 0);
    imem_rdata = (w == 0) ? mem_word(exp_pc) : 32'hDEAD_BEEF;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    if (w > 0) begin
      chk("wait_req", 32'(imem_req), 32'd0);
      chk("wait_ival", 32'(inst_valid), 32'd0);
      repeat (w - 1) tick();
      imem_rvalid = 1'b1; imem_rdata = mem_word(exp_pc);
      tick();
      imem_rvalid = 1'b0;
    end
    chk("hold_ival", 32'(inst_valid), 32'd1);
    chk("hold_inst", inst, mem_word(exp_pc));
    chk("hold_pc",   pc, exp_pc);
    chk("hold_pc4",  pc4, exp_pc + 32'd4);
    chk("hold_req",  32'(imem_req), 32'd0);
  endtask

  // Ack the held instruction, then check the next request or the misalign fault.
  task automatic do_ack(input logic [31:0] cur, input logic [1:0] op, input logic bt,
                        input logic [31:0] off, input logic [31:0] tgt,
                        output logic [31:0] nxt);
    nxt = ref_npc(cur, op, bt, off, tgt);
    inst_ack = 1'b1; npc_op = op; br_taken = bt; br_offset = off; jmp_target = tgt;
    tick();
    inst_ack = 1'b0;
    chk("ack_ival", 32'(inst_valid), 32'd0);
    if (nxt[1]) begin
      chk("mis_fault", 32'(fault), 32'd1);
      chk("mis_cause", 32'(fault_cause), 32'd1);
      chk("mis_pc",    pc, nxt);
      chk("mis_req",   32'(imem_req), 32'd0);
    end else begin
      chk("next_req",  32'(imem_req), 32'd1);
      chk("next_addr", imem_addr, nxt);
      chk("no_fault",  32'(fault), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] cur;
    logic [31:0] nxt;
    logic [31:0] held;

    do_reset();

    // Sequential fetch with a zero-wait memory.
    cur = RST_PC;
    for (int i = 0; i < 3; i++) begin
      do_fetch(cur, 0, 0);
      do_ack(cur, 2'b00, 1'b0, 32'd0, 32'd0, nxt);
      cur = nxt;
    end
    chk("seq_pc", cur, 32'h0000_000C);

    // Conditional branch taken (backwards) and not taken from pc=0x10.
    do_fetch(cur, 0, 1);
    do_ack(cur, 2'b10, 1'b0, 32'd0, 32'h0000_0010, nxt); cur = nxt;
    do_fetch(cur, 1, 0);
    do_ack(cur, 2'b01, 1'b1, 32'hFFFF_FFF8, 32'd0, nxt); cur = nxt;
    chk("br_taken_pc", cur, 32'h0000_0008);
    do_fetch(cur, 0, 0);
    do_ack(cur, 2'b10, 1'b0, 32'd0, 32'h0000_0010, nxt); cur = nxt;
    do_fetch(cur, 0, 2);
    do_ack(cur, 2'b01, 1'b0, 32'hFFFF_FFF8, 32'd0, nxt); cur = nxt;
    chk("br_not_taken_pc", cur, 32'h0000_0014);

    // Absolute jump with bit 0 set in the target; bit 0 is cleared.
    do_fetch(cur, 0, 0);
    do_ack(cur, 2'b10, 1'b0, 32'd0, 32'h0000_0101, nxt); cur = nxt;
    chk("absjmp_pc", cur, 32'h0000_0100);

    // Ack withheld for 10 cycles; a stray rvalid with new data must not disturb the hold.
    do_fetch(cur, 0, 0);
    held = mem_word(cur);
    for (int i = 0; i < 10; i++) begin
      imem_rvalid = (i == 3); imem_rdata = 32'hCAFE_F00D;
      tick();
      imem_rvalid = 1'b0;
      chk("stall_inst", inst, held);
      chk("stall_pc",   pc, cur);
      chk("stall_req",  32'(imem_req), 32'd0);
      chk("stall_ival", 32'(inst_valid), 32'd1);
    end
    do_ack(cur, 2'b11, 1'b1, 32'h0000_0040, 32'd0, nxt); cur = nxt;

    // Randomized program flow with random memory latency.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic        bt;
      logic [31:0] off;
      logic [31:0] tgt;
      op  = 2'($urandom_range(0, 3));
      bt  = 1'($urandom_range(0, 1));
      off = ($urandom & 32'h0000_00FC) - 32'h0000_0080;
      tgt = $urandom & 32'hFFFF_FFFD;
      do_fetch(cur, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      do_ack(cur, op, bt, off, tgt, nxt);
      cur = nxt;
    end

    // Misaligned jump target, then the unit stays halted.
    do_fetch(cur, 0, 0);
    do_ack(cur, 2'b10, 1'b0, 32'd0, 32'h0000_0102, nxt);
    for (int i = 0; i < 4; i++) begin
      imem_gnt = 1'b1; imem_rvalid = 1'b1; inst_ack = 1'b1;
      tick();
      chk("halt_req",   32'(imem_req), 32'd0);
      chk("halt_ival",  32'(inst_valid), 32'd0);
      chk("halt_cause", 32'(fault_cause), 32'd1);
    end
    imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ack = 1'b0;

    // Timeout: rvalid withheld for the whole window.
    do_reset();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    repeat (TO - 2) tick();
    chk("to_pre_fault", 32'(fault), 32'd0);
    tick();
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_cause", 32'(fault_cause), 32'd2);
    chk("to_req",   32'(imem_req), 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_2222;
    tick(); tick();
    imem_rvalid = 1'b0;
    chk("to_halt_ival", 32'(inst_valid), 32'd0);
    chk("to_halt_req",  32'(imem_req), 32'd0);

    // Timeout window: rvalid arrives in the very last cycle and wins.
    do_reset();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    repeat (TO - 2) tick();
    imem_rvalid = 1'b1; imem_rdata = mem_word(RST_PC);
    tick();
    imem_rvalid = 1'b0;
    chk("to_last_fault", 32'(fault), 32'd0);
    chk("to_last_ival",  32'(inst_valid), 32'd1);
    chk("to_last_inst",  inst, mem_word(RST_PC));
    cur = RST_PC;
    do_ack(cur, 2'b10, 1'b0, 32'd0, 32'h0000_0040, nxt); cur = nxt;

    // Reset while waiting for rvalid: outputs clear at once and fetch restarts at RESET_PC.
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    tick();
    chk("pre_rst_addr", imem_addr, 32'h0000_0040);
    rst = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'h5555_AAAA;
    #1;
    chk("async_rst_pc",   pc, RST_PC);
    chk("async_rst_addr", imem_addr, RST_PC);
    chk("async_rst_req",  32'(imem_req), 32'd0);
    chk("async_rst_ival", 32'(inst_valid), 32'd0);
    tick();
    rst = 1'b0;
    imem_rvalid = 1'b0;
    tick();
    chk("restart_ival", 32'(inst_valid), 32'd0);
    do_fetch(RST_PC, 0, 1);
    do_ack(RST_PC, 2'b00, 1'b0, 32'd0, 32'd0, nxt);
    chk("restart_next", nxt, 32'h0000_0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
